systemizer_redo_ctrl: RTL and testbench

//  Sequences one systemizer instance through a full key-generation attempt: matrix load, left (pivot) pass, right pass.
//  On early-abort fail it requests a fresh matrix and retries, up to MAX_TRIES attempts.

---
 rtl/systemizer_redo_ctrl_if.sv | 64 ++++++
 rtl/systemizer_redo_ctrl.sv | 133 +++++++++++++
 tb/tb_systemizer_redo_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/systemizer_redo_ctrl_if.sv
// Bundle between the redo controller, keygen FSM, matrix generator,
// host readout and the systemizer memory/control port.
interface systemizer_redo_ctrl_if #(
    parameter int AW = 12,
    parameter int DW = 20,
    parameter int CW = 4
);
    logic          req;
    logic          abort;
    logic          busy;
    logic          ok;
    logic          err;
    logic [CW-1:0] attempts;

    logic          gen_start;
    logic          gen_done;
    logic          gen_wr_en;
    logic [AW-1:0] gen_wr_addr;
    logic [DW-1:0] gen_din;

    logic          host_rd_en;
    logic [AW-1:0] host_rd_addr;
    logic [DW-1:0] host_dout;

    logic          sys_start;
    logic          sys_start_right;
    logic          sys_success;
    logic          sys_fail;
    logic          sys_done;
    logic          sys_wr_en;
    logic [AW-1:0] sys_wr_addr;
    logic [DW-1:0] sys_din;
    logic          sys_rd_en;
    logic [AW-1:0] sys_rd_addr;
    logic [DW-1:0] sys_dout;

    modport slave (
        input  req, abort,
        output busy, ok, err, attempts,
        output gen_start,
        input  gen_done, gen_wr_en, gen_wr_addr, gen_din,
        input  host_rd_en, host_rd_addr,
        output host_dout,
        output sys_start, sys_start_right,
        input  sys_success, sys_fail, sys_done,
        output sys_wr_en, sys_wr_addr, sys_din,
        output sys_rd_en, sys_rd_addr,
        input  sys_dout
    );

    modport master (
        output req, abort,
        input  busy, ok, err, attempts,
        input  gen_start,
        output gen_done, gen_wr_en, gen_wr_addr, gen_din,
        output host_rd_en, host_rd_addr,
        input  host_dout,
        input  sys_start, sys_start_right,
        output sys_success, sys_fail, sys_done,
        input  sys_wr_en, sys_wr_addr, sys_din,
        input  sys_rd_en, sys_rd_addr,
        output sys_dout
    );
endinterface

// File: rtl/systemizer_redo_ctrl.sv
// Drives one systemizer through load/left/right passes with bounded
// retries, and owns the mux on the systemizer memory port.
module systemizer_redo_ctrl #(
    parameter int M         = 1,
    parameter int N         = 20,
    parameter int L         = 200,
    parameter int K         = 400,
    parameter int MAX_TRIES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    systemizer_redo_ctrl_if.slave bus
);
    localparam int CW = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LEFT,
        S_RIGHT,
        S_PASS,
        S_FAIL
    } state_t;

    state_t        r_state;
    state_t        r_prev;
    state_t        w_next;
    logic          r_ok;
    logic          r_err;
    logic          r_gen_start;
    logic          r_sys_start;
    logic          r_sys_start_right;
    logic [CW-1:0] r_attempts;
    logic          w_abort;
    logic          w_entry;
    logic          w_last_try;

    assign w_abort    = bus.abort && (r_state != S_IDLE);
    assign w_entry    = (r_state != r_prev);
    assign w_last_try = (r_attempts >= CW'(MAX_TRIES));

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:  if (bus.req) w_next = S_LOAD;
                S_LOAD:  if (bus.gen_done) w_next = S_LEFT;
                S_LEFT: begin
                    // a simultaneous success is discarded when fail is seen
                    if (bus.sys_fail)
                        w_next = w_last_try ? S_FAIL : S_LOAD;
                    else if (bus.sys_success)
                        w_next = S_RIGHT;
                end
                S_RIGHT: begin
                    if (bus.sys_fail)
                        w_next = S_FAIL;
                    else if (bus.sys_done)
                        w_next = S_PASS;
                end
                S_PASS:  w_next = S_IDLE;
                S_FAIL:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state           <= S_IDLE;
            r_prev            <= S_IDLE;
            r_ok              <= 1'b0;
            r_err             <= 1'b0;
            r_gen_start       <= 1'b0;
            r_sys_start       <= 1'b0;
            r_sys_start_right <= 1'b0;
            r_attempts        <= '0;
        end else begin
            r_state <= w_next;
            r_prev  <= r_state;

            r_gen_start <= w_entry && !w_abort &&
                           (r_state == S_LOAD);
            r_sys_start <= w_entry && !w_abort &&
                           (r_state == S_LEFT);
            r_sys_start_right <= w_entry && !w_abort &&
                                 (r_state == S_RIGHT);

            if (r_state == S_IDLE) begin
                if (bus.req) begin
                    r_attempts <= CW'(1);
                    r_ok       <= 1'b0;
                    r_err      <= 1'b0;
                end
            end else if (w_next == S_LOAD && r_state != S_LOAD &&
                         !w_last_try) begin
                r_attempts <= r_attempts + CW'(1);
            end

            if (w_abort || r_state == S_FAIL)
                r_err <= 1'b1;
            if (r_state == S_PASS && !w_abort)
                r_ok <= 1'b1;
        end
    end

    assign bus.busy            = (r_state != S_IDLE);
    assign bus.ok              = r_ok;
    assign bus.err             = r_err;
    assign bus.attempts        = r_attempts;
    assign bus.gen_start       = r_gen_start;
    assign bus.sys_start       = r_sys_start;
    assign bus.sys_start_right = r_sys_start_right;
    assign bus.host_dout       = bus.sys_dout;

    always_comb begin
        bus.sys_wr_en   = 1'b0;
        bus.sys_wr_addr = '0;
        bus.sys_din     = '0;
        bus.sys_rd_en   = 1'b0;
        bus.sys_rd_addr = '0;
        if (r_state == S_LOAD) begin
            bus.sys_wr_en   = bus.gen_wr_en;
            bus.sys_wr_addr = bus.gen_wr_addr;
            bus.sys_din     = bus.gen_din;
        end else if (r_state == S_IDLE) begin
            bus.sys_rd_en   = bus.host_rd_en;
            bus.sys_rd_addr = bus.host_rd_addr;
        end
    end
endmodule

// File: tb/tb_systemizer_redo_ctrl.sv
// Directed bench for systemizer_redo_ctrl: sequencing, retries,
// abort, reset and memory-port muxing.
module tb_systemizer_redo_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;
    int   n_gs   = 0;
    int   n_ss   = 0;
    int   n_sr   = 0;

    always #5 clk = ~clk;

    systemizer_redo_ctrl_if #(.AW(3), .DW(8), .CW(2)) bus ();

    systemizer_redo_ctrl #(
        .M(2), .N(4), .L(4), .K(8), .MAX_TRIES(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always @(negedge clk) begin
        if (bus.gen_start)       n_gs++;
        if (bus.sys_start)       n_ss++;
        if (bus.sys_start_right) n_sr++;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus.gen_start;
            1:       return bus.sys_start;
            default: return bus.sys_start_right;
        endcase
    endfunction

    task automatic wait_hi(input string tag, input int sel,
                           output int n);
        n = 0;
        while (!sig(sel) && n < 50) begin
            tick();
            n++;
        end
        chk({tag, " no-timeout"}, 32'(n < 50), 1);
    endtask

    task automatic req_pulse();
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
    endtask

    task automatic in_pulse(input int sel);
        case (sel)
            0:       bus.gen_done    = 1'b1;
            1:       bus.sys_success = 1'b1;
            2:       bus.sys_fail    = 1'b1;
            default: bus.sys_done    = 1'b1;
        endcase
        tick();
        bus.gen_done    = 1'b0;
        bus.sys_success = 1'b0;
        bus.sys_fail    = 1'b0;
        bus.sys_done    = 1'b0;
    endtask

    task automatic do_abort();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int gs0;
        int ss0;
        int sr0;
        bus.req = 0; bus.abort = 0; bus.gen_done = 0;
        bus.gen_wr_en = 0; bus.gen_wr_addr = 0; bus.gen_din = 0;
        bus.host_rd_en = 0; bus.host_rd_addr = 0;
        bus.sys_success = 0; bus.sys_fail = 0; bus.sys_done = 0;
        bus.sys_dout = 0;

        #2 rst = 1'b0;
        #1;
        chk("rst busy", 32'(bus.busy), 0);
        chk("rst ok", 32'(bus.ok), 0);
        chk("rst err", 32'(bus.err), 0);
        chk("rst attempts", 32'(bus.attempts), 0);
        chk("rst gen_start", 32'(bus.gen_start), 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // 1: single clean attempt
        gs0 = n_gs; ss0 = n_ss; sr0 = n_sr;
        req_pulse();
        chk("t1 busy", 32'(bus.busy), 1);
        wait_hi("t1 gs", 0, n);
        chk("t1 req->gen_start", 32'(n + 1), 2);
        repeat (10) tick();
        in_pulse(0);
        wait_hi("t1 ss", 1, n);
        chk("t1 done->sys_start", 32'(n + 1), 2);
        in_pulse(1);
        wait_hi("t1 sr", 2, n);
        chk("t1 succ->start_right", 32'(n + 1), 2);
        in_pulse(3);
        chk("t1 pass busy", 32'(bus.busy), 1);
        tick();
        chk("t1 idle busy", 32'(bus.busy), 0);
        chk("t1 ok", 32'(bus.ok), 1);
        chk("t1 err", 32'(bus.err), 0);
        chk("t1 attempts", 32'(bus.attempts), 1);
        tick();
        chk("t1 n gen_start", 32'(n_gs - gs0), 1);
        chk("t1 n sys_start", 32'(n_ss - ss0), 1);
        chk("t1 n start_right", 32'(n_sr - sr0), 1);

        // 2: fail, fail, succeed
        gs0 = n_gs;
        req_pulse();
        chk("t2 ok cleared", 32'(bus.ok), 0);
        for (int t = 1; t <= 3; t++) begin
            wait_hi("t2 gs", 0, n);
            chk("t2 retry latency", 32'(n), 1);
            chk("t2 attempts", 32'(bus.attempts), 32'(t));
            tick();
            in_pulse(0);
            wait_hi("t2 ss", 1, n);
            in_pulse(t < 3 ? 2 : 1);
        end
        wait_hi("t2 sr", 2, n);
        in_pulse(3);
        tick();
        chk("t2 ok", 32'(bus.ok), 1);
        chk("t2 attempts end", 32'(bus.attempts), 3);
        tick();
        chk("t2 n gen_start", 32'(n_gs - gs0), 3);

        // 3: every try fails; success in same cycle loses
        gs0 = n_gs; sr0 = n_sr;
        req_pulse();
        for (int t = 1; t <= 3; t++) begin
            wait_hi("t3 gs", 0, n);
            in_pulse(0);
            wait_hi("t3 ss", 1, n);
            bus.sys_success = 1'b1;
            in_pulse(2);
        end
        chk("t3 fail busy", 32'(bus.busy), 1);
        tick();
        chk("t3 busy", 32'(bus.busy), 0);
        chk("t3 err", 32'(bus.err), 1);
        chk("t3 ok", 32'(bus.ok), 0);
        chk("t3 attempts", 32'(bus.attempts), 3);
        repeat (3) tick();
        chk("t3 n start_right", 32'(n_sr - sr0), 0);
        chk("t3 n gen_start", 32'(n_gs - gs0), 3);

        // 4: abort in RIGHT, then restart; abort on LOAD entry
        req_pulse();
        chk("t4 err cleared", 32'(bus.err), 0);
        wait_hi("t4 gs", 0, n);
        in_pulse(0);
        wait_hi("t4 ss", 1, n);
        in_pulse(1);
        wait_hi("t4 sr", 2, n);
        do_abort();
        chk("t4 abort busy", 32'(bus.busy), 0);
        chk("t4 abort err", 32'(bus.err), 1);
        req_pulse();
        chk("t4 re err", 32'(bus.err), 0);
        wait_hi("t4 re gs", 0, n);
        chk("t4 re attempts", 32'(bus.attempts), 1);
        do_abort();
        gs0 = n_gs;
        req_pulse();
        do_abort();
        repeat (3) tick();
        chk("t4 pulse suppressed", 32'(n_gs - gs0), 0);
        chk("t4 early abort err", 32'(bus.err), 1);

        // 5: memory port mux
        req_pulse();
        bus.gen_wr_en = 1; bus.gen_wr_addr = 3'd7;
        bus.gen_din = 8'hA5; bus.host_rd_en = 1;
        bus.host_rd_addr = 3'd7;
        #1;
        chk("t5 load wr_en", 32'(bus.sys_wr_en), 1);
        chk("t5 load wr_addr", 32'(bus.sys_wr_addr), 7);
        chk("t5 load din", 32'(bus.sys_din), 32'hA5);
        chk("t5 load rd_en", 32'(bus.sys_rd_en), 0);
        in_pulse(0);
        chk("t5 left wr_en", 32'(bus.sys_wr_en), 0);
        chk("t5 left wr_addr", 32'(bus.sys_wr_addr), 0);
        chk("t5 left din", 32'(bus.sys_din), 0);
        chk("t5 left rd_en", 32'(bus.sys_rd_en), 0);
        do_abort();
        bus.sys_dout = 8'h3C;
        #1;
        chk("t5 idle rd_en", 32'(bus.sys_rd_en), 1);
        chk("t5 idle rd_addr", 32'(bus.sys_rd_addr), 7);
        chk("t5 idle dout", 32'(bus.host_dout), 32'h3C);
        chk("t5 idle wr_en", 32'(bus.sys_wr_en), 0);
        bus.gen_wr_en = 0; bus.host_rd_en = 0;
        bus.gen_wr_addr = 0; bus.gen_din = 0;
        bus.host_rd_addr = 0;
        tick();

        // 6: req while busy ignored; async reset mid-LEFT
        req_pulse();
        wait_hi("t6 gs", 0, n);
        in_pulse(0);
        wait_hi("t6 ss", 1, n);
        gs0 = n_gs;
        req_pulse();
        tick();
        chk("t6 busy req attempts", 32'(bus.attempts), 1);
        chk("t6 busy req gs", 32'(n_gs - gs0), 0);
        chk("t6 still busy", 32'(bus.busy), 1);
        #2 rst = 1'b0;
        #1;
        chk("t6 rst busy", 32'(bus.busy), 0);
        chk("t6 rst attempts", 32'(bus.attempts), 0);
        chk("t6 rst err", 32'(bus.err), 0);
        chk("t6 rst sys_start", 32'(bus.sys_start), 0);
        chk("t6 rst rd_en idle", 32'(bus.sys_rd_en), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("t6 after rst busy", 32'(bus.busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
